// File: rtl/ex_stage_pkg.sv
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared constants, packet layouts, ALU opcode bit positions,
//               divider state encoding and the combinational ALU used by the
//               EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_stage_pkg;

    localparam int TO_EX_DATA_WIDTH  = 157;
    localparam int TO_MEM_DATA_WIDTH = 75;
    localparam int EX_FORWARD_WIDTH  = 38;
    localparam int ALU_OP_WIDTH      = 12;

    // One-hot alu_op bit positions
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    // Field order is MSB first, matching the bus packing from ID.
    typedef struct packed {
        logic [31:0]             pc;
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic [31:0]             src1;
        logic [31:0]             src2;
        logic                    div_en;
        logic                    div_signed;
        logic                    div_rem;
        logic                    ld_1b;
        logic                    ld_2b;
        logic                    ld_4b;
        logic                    ld_signed;
        logic                    st_1b;
        logic                    st_2b;
        logic                    st_4b;
        logic [31:0]             st_data;
        logic [4:0]              dest;
        logic                    gr_we;
        logic                    ex_SYS;
    } to_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic        ld_1b;
        logic        ld_2b;
        logic        ld_4b;
        logic        ld_signed;
        logic [4:0]  dest;
        logic        gr_we;
        logic        ex_SYS;
    } to_mem_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // One-hot ALU: each selected operation ORs its result into the output.
    function automatic logic [31:0] alu_calc(
        input logic [ALU_OP_WIDTH-1:0] op,
        input logic [31:0]             a,
        input logic [31:0]             b
    );
        logic [31:0] res;
        res = '0;
        if (op[OP_ADD])  res = res | (a + b);
        if (op[OP_SUB])  res = res | (a - b);
        if (op[OP_SLT])  res = res | {31'd0, ($signed(a) < $signed(b))};
        if (op[OP_SLTU]) res = res | {31'd0, (a < b)};
        if (op[OP_AND])  res = res | (a & b);
        if (op[OP_NOR])  res = res | ~(a | b);
        if (op[OP_OR])   res = res | (a | b);
        if (op[OP_XOR])  res = res | (a ^ b);
        if (op[OP_SLL])  res = res | (a << b[4:0]);
        if (op[OP_SRL])  res = res | (a >> b[4:0]);
        if (op[OP_SRA])  res = res | $unsigned($signed(a) >>> b[4:0]);
        if (op[OP_LUI])  res = res | b;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_div.sv
// ============================================================================
// Module      : div_unit
// Description : 32-bit radix-2 restoring divider working on magnitudes.
//               IDLE -> BUSY on start; BUSY runs 32 iteration cycles plus one
//               sign-fixup cycle, then DONE holds the result until ack.
//               Divide-by-zero yields quotient all-ones, remainder = dividend.
// Ports       : clk, reset (sync, active-high), flush_i (abort to IDLE),
//               start_i, ack_i (DONE release), signed_i, dividend_i,
//               divisor_i -> busy_o, done_o, quotient_o, remainder_o
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        start_i,
    input  logic        ack_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    localparam logic [5:0] C_ITER_LAST = 6'd32;

    div_state_e  state_q;
    logic [5:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvsr_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        div_zero_q;

    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [32:0] partial;
    logic [33:0] trial;
    logic [31:0] rem_step;
    logic        qbit;

    assign dividend_mag = (signed_i && dividend_i[31]) ? (32'd0 - dividend_i) : dividend_i;
    assign divisor_mag  = (signed_i && divisor_i[31])  ? (32'd0 - divisor_i)  : divisor_i;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    always_comb begin
        partial  = {rem_q, quo_q[31]};
        trial    = {1'b0, partial} - {2'b00, dvsr_q};
        qbit     = ~trial[33];
        rem_step = qbit ? trial[31:0] : partial[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        state_q    <= DIV_BUSY;
                        cnt_q      <= '0;
                        quo_q      <= dividend_mag;
                        rem_q      <= '0;
                        dvsr_q     <= divisor_mag;
                        neg_quo_q  <= signed_i & (dividend_i[31] ^ divisor_i[31]);
                        neg_rem_q  <= signed_i & dividend_i[31];
                        div_zero_q <= (divisor_i == 32'd0);
                    end
                end
                DIV_BUSY: begin
                    if (cnt_q == C_ITER_LAST) begin
                        // Sign fixup; quo_q/rem_q then hold the final result.
                        quo_q   <= div_zero_q ? 32'hFFFF_FFFF
                                 : (neg_quo_q ? (32'd0 - quo_q) : quo_q);
                        rem_q   <= neg_rem_q ? (32'd0 - rem_q) : rem_q;
                        state_q <= DIV_DONE;
                    end else begin
                        quo_q <= {quo_q[30:0], qbit};
                        rem_q <= rem_step;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DIV_DONE: begin
                    if (ack_i) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q == DIV_BUSY);
    assign done_o      = (state_q == DIV_DONE);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module      : ex_stage
// Description : Pipeline execute stage. Latches the ID packet, computes the
//               ALU or divider result, issues the data SRAM request and
//               forwards the destination/result to ID.
// Ports       : clk, reset (sync, active-high), wb_ex (exception flush)
//               ID_to_EX_valid/EX_allow_in, EX_to_MEM_valid/MEM_allow_in
//               to_EX_data in, to_MEM_data out
//               data_sram_en/we/addr/wdata out, EX_forward out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wb_ex,
    input  logic                         ID_to_EX_valid,
    output logic                         EX_allow_in,
    input  logic                         MEM_allow_in,
    output logic                         EX_to_MEM_valid,
    input  logic [TO_EX_DATA_WIDTH-1:0]  to_EX_data,
    output logic [TO_MEM_DATA_WIDTH-1:0] to_MEM_data,
    output logic                         data_sram_en,
    output logic [3:0]                   data_sram_we,
    output logic [31:0]                  data_sram_addr,
    output logic [31:0]                  data_sram_wdata,
    output logic [EX_FORWARD_WIDTH-1:0]  EX_forward
);

    logic    ex_valid_q, ex_valid_d;
    to_ex_t  ex_data_q, ex_data_d;
    to_mem_t mem_pkt;

    logic        ex_ready_go;
    logic        is_load;
    logic        is_store;
    logic [31:0] alu_result;
    logic [31:0] ex_result;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    // ---------------- pipeline register ----------------
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_data_d  = ex_data_q;
        if (EX_allow_in) begin
            ex_valid_d = ID_to_EX_valid;
        end
        if (ID_to_EX_valid && EX_allow_in) begin
            ex_data_d = to_EX_data;
        end
        // Exception flush wins over a packet arriving in the same cycle.
        if (wb_ex) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_data_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_data_q  <= ex_data_d;
        end
    end

    // ---------------- handshake ----------------
    assign ex_ready_go     = ~ex_data_q.div_en | div_done;
    // div_busy only occurs with a divide packet resident, so it never blocks
    // an empty stage; it makes the no-accept-while-dividing rule explicit.
    assign EX_allow_in     = ~ex_valid_q | (ex_ready_go & MEM_allow_in & ~div_busy);
    assign EX_to_MEM_valid = ex_valid_q & ex_ready_go;

    // ---------------- execute ----------------
    assign div_start = ex_valid_q & ex_data_q.div_en & ~wb_ex;

    div_unit u_div (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (wb_ex),
        .start_i     (div_start),
        .ack_i       (MEM_allow_in),
        .signed_i    (ex_data_q.div_signed),
        .dividend_i  (ex_data_q.src1),
        .divisor_i   (ex_data_q.src2),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign alu_result = alu_calc(ex_data_q.alu_op, ex_data_q.src1, ex_data_q.src2);
    assign ex_result  = ex_data_q.div_en ? (ex_data_q.div_rem ? div_rem : div_quo)
                                         : alu_result;

    // ---------------- data SRAM request ----------------
    assign is_load  = ex_data_q.ld_1b | ex_data_q.ld_2b | ex_data_q.ld_4b;
    assign is_store = ex_data_q.st_1b | ex_data_q.st_2b | ex_data_q.st_4b;

    assign data_sram_en   = ex_valid_q & (is_load | is_store);
    assign data_sram_addr = alu_result;

    // Byte enables are suppressed for syscall packets and during a flush so
    // a squashed store never reaches memory.
    always_comb begin
        data_sram_we = 4'b0000;
        if (ex_valid_q && is_store && !ex_data_q.ex_SYS && !wb_ex) begin
            if (ex_data_q.st_1b) begin
                data_sram_we = 4'b0001 << alu_result[1:0];
            end else if (ex_data_q.st_2b) begin
                data_sram_we = 4'b0011 << alu_result[1:0];
            end else begin
                data_sram_we = 4'b1111;
            end
        end
    end

    always_comb begin
        if (ex_data_q.st_1b) begin
            data_sram_wdata = {4{ex_data_q.st_data[7:0]}};
        end else if (ex_data_q.st_2b) begin
            data_sram_wdata = {2{ex_data_q.st_data[15:0]}};
        end else begin
            data_sram_wdata = ex_data_q.st_data;
        end
    end

    // ---------------- outputs to MEM and ID ----------------
    always_comb begin
        mem_pkt.pc        = ex_data_q.pc;
        mem_pkt.result    = ex_result;
        mem_pkt.ld_1b     = ex_data_q.ld_1b;
        mem_pkt.ld_2b     = ex_data_q.ld_2b;
        mem_pkt.ld_4b     = ex_data_q.ld_4b;
        mem_pkt.ld_signed = ex_data_q.ld_signed;
        mem_pkt.dest      = ex_data_q.dest;
        mem_pkt.gr_we     = ex_data_q.gr_we;
        mem_pkt.ex_SYS    = ex_data_q.ex_SYS;
    end

    assign to_MEM_data = mem_pkt;

    assign EX_forward = {ex_data_q.dest & {5{ex_valid_q & ex_data_q.gr_we}},
                         ex_result,
                         ex_valid_q & is_load};

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage: table of ALU/load/store
//               vectors plus hand-written divide, flush, reset and stall
//               sequences. Expected MEM packets go through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;
    import ex_stage_pkg::*;

    logic         clk;
    logic         reset;
    logic         wb_ex;
    logic         ID_to_EX_valid;
    logic         EX_allow_in;
    logic         MEM_allow_in;
    logic         EX_to_MEM_valid;
    logic [156:0] to_EX_data;
    logic [74:0]  to_MEM_data;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [37:0]  EX_forward;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [74:0] sb[$];

    ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .wb_ex           (wb_ex),
        .ID_to_EX_valid  (ID_to_EX_valid),
        .EX_allow_in     (EX_allow_in),
        .MEM_allow_in    (MEM_allow_in),
        .EX_to_MEM_valid (EX_to_MEM_valid),
        .to_EX_data      (to_EX_data),
        .to_MEM_data     (to_MEM_data),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .EX_forward      (EX_forward)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] op(input int i);
        logic [11:0] o;
        o    = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    function automatic logic [156:0] mkpkt(input logic [31:0] pc, input logic [11:0] aop,
                                           input logic [31:0] s1, input logic [31:0] s2,
                                           input logic [2:0] dv, input logic [3:0] ld,
                                           input logic [2:0] st, input logic [31:0] sd,
                                           input logic [4:0] dest, input logic gwe,
                                           input logic sys);
        return {pc, aop, s1, s2, dv, ld, st, sd, dest, gwe, sys};
    endfunction

    function automatic logic [74:0] mkmem(input logic [31:0] pc, input logic [31:0] res,
                                          input logic [3:0] ld, input logic [4:0] dest,
                                          input logic gwe, input logic sys);
        return {pc, res, ld, dest, gwe, sys};
    endfunction

    // Scoreboard: every MEM handshake must match the oldest expected packet.
    always @(negedge clk) begin
        if (!reset && !wb_ex && EX_to_MEM_valid && MEM_allow_in) begin
            if (sb.size() == 0) begin
                chk("unexpected_mem_packet", to_MEM_data, 75'd0);
            end else begin
                chk("mem_packet", to_MEM_data, sb.pop_front());
            end
        end
    end

    task automatic send(input logic [156:0] pkt, input logic [74:0] exp, input bit push,
                        output int lc);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        ID_to_EX_valid = 1'b1;
        to_EX_data     = pkt;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (EX_allow_in) ok = 1'b1;
        end
        @(posedge clk); #1;
        ID_to_EX_valid = 1'b0;
        lc = cyc;
        if (ok) begin
            if (push) sb.push_back(exp);
        end else begin
            checks++;
            failures++;
            $display("FAIL send_accept: EX_allow_in stayed 0, required 1");
        end
    endtask

    task automatic wait_out(input int lc, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (EX_to_MEM_valid) begin
                lat = cyc - lc;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_out_timeout: no EX_to_MEM_valid, required within 100 cycles");
    endtask

    task automatic div_run(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic rem, input logic [31:0] exp_res, input string nm);
        int lc, lat;
        send(mkpkt(32'h1c00_1000, 12'h000, a, b, {1'b1, sgn, rem}, 4'b0, 3'b0, 32'h0,
                   5'd7, 1'b1, 1'b0),
             mkmem(32'h1c00_1000, exp_res, 4'b0, 5'd7, 1'b1, 1'b0), 1'b1, lc);
        wait_out(lc, lat);
        chk({nm, "_latency"}, lat, 34);
    endtask

    typedef struct {
        logic [11:0] aop;
        logic [31:0] s1, s2;
        logic [3:0]  ld;
        logic [2:0]  st;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic        gwe, sys;
        logic [31:0] res;
        logic [3:0]  we;
        logic [31:0] wd;
        logic        en, isld;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int lc, lat;
        logic [74:0] stall_exp;

        // {aop, s1, s2, ld, st, sd, dest, gwe, sys, res, we, wd, en, isld}
        vecs[0]  = '{op(OP_ADD),  32'd5, 32'd7, 4'b0, 3'b0, 32'h0, 5'd3, 1'b1, 1'b0, 32'd12, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{op(OP_SUB),  32'd5, 32'd7, 4'b0, 3'b0, 32'h0, 5'd4, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{op(OP_SLT),  32'hFFFF_FFFF, 32'd1, 4'b0, 3'b0, 32'h0, 5'd5, 1'b1, 1'b0, 32'd1, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{op(OP_SLTU), 32'hFFFF_FFFF, 32'd1, 4'b0, 3'b0, 32'h0, 5'd6, 1'b1, 1'b0, 32'd0, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{op(OP_AND),  32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0, 3'b0, 32'h0, 5'd8, 1'b1, 1'b0, 32'hF000_F000, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[5]  = '{op(OP_NOR),  32'hF0F0_F0F0, 32'h0F0F_0F00, 4'b0, 3'b0, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0000_000F, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{op(OP_OR),   32'h1234_0000, 32'h0000_5678, 4'b0, 3'b0, 32'h0, 5'd10, 1'b0, 1'b0, 32'h1234_5678, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{op(OP_XOR),  32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0, 3'b0, 32'h0, 5'd11, 1'b1, 1'b0, 32'hF0F0_0F0F, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{op(OP_SLL),  32'd1, 32'd31, 4'b0, 3'b0, 32'h0, 5'd12, 1'b1, 1'b0, 32'h8000_0000, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{op(OP_SRL),  32'h8000_0000, 32'd4, 4'b0, 3'b0, 32'h0, 5'd13, 1'b1, 1'b0, 32'h0800_0000, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{op(OP_SRA),  32'h8000_0000, 32'd4, 4'b0, 3'b0, 32'h0, 5'd14, 1'b1, 1'b0, 32'hF800_0000, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[11] = '{op(OP_LUI),  32'h55, 32'hABCD_E000, 4'b0, 3'b0, 32'h0, 5'd15, 1'b1, 1'b0, 32'hABCD_E000, 4'b0, 32'h0, 1'b0, 1'b0};
        vecs[12] = '{op(OP_ADD),  32'h1000, 32'd3, 4'b0, 3'b100, 32'hAB, 5'd0, 1'b0, 1'b0, 32'h1003, 4'b1000, 32'hABAB_ABAB, 1'b1, 1'b0};
        vecs[13] = '{op(OP_ADD),  32'h1000, 32'd3, 4'b0, 3'b100, 32'hAB, 5'd0, 1'b0, 1'b1, 32'h1003, 4'b0000, 32'hABAB_ABAB, 1'b1, 1'b0};
        vecs[14] = '{op(OP_ADD),  32'h2000, 32'd2, 4'b0, 3'b010, 32'h1234, 5'd0, 1'b0, 1'b0, 32'h2002, 4'b1100, 32'h1234_1234, 1'b1, 1'b0};
        vecs[15] = '{op(OP_ADD),  32'h3000, 32'd0, 4'b0, 3'b001, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'h3000, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[16] = '{op(OP_ADD),  32'h40, 32'd4, 4'b0010, 3'b0, 32'h0, 5'd5, 1'b1, 1'b0, 32'h44, 4'b0, 32'h0, 1'b1, 1'b1};
        vecs[17] = '{op(OP_ADD),  32'h100, 32'd1, 4'b0, 3'b100, 32'h5A, 5'd0, 1'b0, 1'b0, 32'h101, 4'b0010, 32'h5A5A_5A5A, 1'b1, 1'b0};

        reset = 1'b1; wb_ex = 1'b0; ID_to_EX_valid = 1'b0; MEM_allow_in = 1'b1;
        to_EX_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_to_mem_valid", EX_to_MEM_valid, 1'b0);
        chk("reset_sram_en", data_sram_en, 1'b0);
        chk("reset_sram_we", data_sram_we, 4'b0);
        chk("reset_fwd_dest", EX_forward[37:33], 5'd0);
        chk("reset_allow_in", EX_allow_in, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;

        // ---- table-driven single-cycle packets ----
        for (int i = 0; i < 18; i++) begin
            send(mkpkt(32'h1c00_0000 + 32'(i * 4), vecs[i].aop, vecs[i].s1, vecs[i].s2, 3'b0,
                       vecs[i].ld, vecs[i].st, vecs[i].sd, vecs[i].dest, vecs[i].gwe, vecs[i].sys),
                 mkmem(32'h1c00_0000 + 32'(i * 4), vecs[i].res, vecs[i].ld, vecs[i].dest,
                       vecs[i].gwe, vecs[i].sys), 1'b1, lc);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), EX_to_MEM_valid, 1'b1);
            chk($sformatf("vec%0d_we", i), data_sram_we, vecs[i].we);
            chk($sformatf("vec%0d_wdata", i), data_sram_wdata, vecs[i].wd);
            chk($sformatf("vec%0d_en", i), data_sram_en, vecs[i].en);
            chk($sformatf("vec%0d_addr", i), data_sram_addr, vecs[i].res);
            chk($sformatf("vec%0d_fwd", i), EX_forward,
                {(vecs[i].gwe ? vecs[i].dest : 5'd0), vecs[i].res, vecs[i].isld});
        end

        // ---- divides ----
        div_run(32'd100, 32'd7, 1'b0, 1'b1, 32'd2, "div100_7_rem");
        div_run(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, "div100_7_quo");
        div_run(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, "sdiv_m7_2_quo");
        div_run(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, "sdiv_m7_2_rem");
        div_run(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1, "sdiv_7_m2_rem");
        div_run(32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, "div5_0_quo");
        div_run(32'd5, 32'd0, 1'b0, 1'b1, 32'd5, "div5_0_rem");
        div_run(32'hFFFF_FFF8, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, "sdiv_m8_0_quo");
        div_run(32'hFFFF_FFF8, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFF8, "sdiv_m8_0_rem");
        div_run(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 32'h0FFF_FFFF, "divmax_16_quo");

        // ---- flush suppresses store enables ----
        send(mkpkt(32'h1c00_2000, op(OP_ADD), 32'h3000, 32'd0, 3'b0, 4'b0, 3'b001,
                   32'h1111_2222, 5'd0, 1'b0, 1'b0), 75'd0, 1'b0, lc);
        wb_ex = 1'b1;
        @(negedge clk);
        chk("flush_store_we", data_sram_we, 4'b0);
        @(posedge clk); #1;
        wb_ex = 1'b0;
        @(negedge clk);
        chk("flush_store_gone", EX_to_MEM_valid, 1'b0);

        // ---- flush mid-divide at BUSY cycle 10 ----
        send(mkpkt(32'h1c00_3000, 12'h000, 32'd1000, 32'd3, 3'b100, 4'b0, 3'b0, 32'h0,
                   5'd9, 1'b1, 1'b0), 75'd0, 1'b0, lc);
        repeat (10) @(posedge clk);
        #1;
        wb_ex = 1'b1;
        @(negedge clk);
        chk("busy_blocks_accept", EX_allow_in, 1'b0);
        chk("busy_not_valid", EX_to_MEM_valid, 1'b0);
        @(posedge clk); #1;
        wb_ex = 1'b0;
        @(negedge clk);
        chk("flush_allow_in", EX_allow_in, 1'b1);
        chk("flush_fwd_dest", EX_forward[37:33], 5'd0);
        send(mkpkt(32'h1c00_3004, op(OP_ADD), 32'd40, 32'd2, 3'b0, 4'b0, 3'b0, 32'h0,
                   5'd2, 1'b1, 1'b0),
             mkmem(32'h1c00_3004, 32'd42, 4'b0, 5'd2, 1'b1, 1'b0), 1'b1, lc);
        wait_out(lc, lat);
        chk("add_after_flush_latency", lat, 0);

        // ---- flush wins over a simultaneous new packet ----
        @(posedge clk); #1;
        ID_to_EX_valid = 1'b1;
        to_EX_data = mkpkt(32'h1c00_3008, op(OP_ADD), 32'd1, 32'd1, 3'b0, 4'b0, 3'b0,
                           32'h0, 5'd1, 1'b1, 1'b0);
        wb_ex = 1'b1;
        @(posedge clk); #1;
        ID_to_EX_valid = 1'b0;
        wb_ex = 1'b0;
        @(negedge clk);
        chk("flush_beats_latch", EX_to_MEM_valid, 1'b0);

        // ---- reset mid-divide ----
        send(mkpkt(32'h1c00_4000, 12'h000, 32'd999, 32'd9, 3'b100, 4'b0, 3'b0, 32'h0,
                   5'd3, 1'b1, 1'b0), 75'd0, 1'b0, lc);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_allow_in", EX_allow_in, 1'b1);
        chk("rst_mid_valid", EX_to_MEM_valid, 1'b0);
        div_run(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, "div_after_reset");

        // ---- MEM stall while DONE ----
        stall_exp = mkmem(32'h1c00_5000, 32'd14, 4'b0, 5'd7, 1'b1, 1'b0);
        send(mkpkt(32'h1c00_5000, 12'h000, 32'd100, 32'd7, 3'b100, 4'b0, 3'b0, 32'h0,
                   5'd7, 1'b1, 1'b0), stall_exp, 1'b1, lc);
        MEM_allow_in = 1'b0;
        wait_out(lc, lat);
        chk("stall_latency", lat, 34);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_data", k), to_MEM_data, stall_exp);
            chk($sformatf("stall%0d_allow_in", k), EX_allow_in, 1'b0);
            if (k < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        MEM_allow_in = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_released", EX_to_MEM_valid, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
